fetch_buffer: RTL

Parametrised instruction-fetch front end for the pipelined core: owns the program counter, issues addresses to the synchronous instruction ROM, and buffers returned instructions with their PCs in a DEPTH-entry queue. Replaces the fixed single-register fetch/decode boundary with a valid/ready interface, stall back-pressure, and branch-redirect flush. Sits between the instruction ROM and the decoder.

---
 rtl/fetch_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end. Owns the PC, issues requests to a
// synchronous ROM (one-cycle read latency) and queues returned {inst, pc}
// pairs in a DEPTH-entry circular buffer presented to the decoder with
// valid/ready. A redirect flushes everything and restarts fetch at redirect_pc.
module fetch_buffer #(
  parameter int          INST_W   = 26,
  parameter int          PC_W     = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]          imem_data,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [INST_W-1:0] mem_inst_q [DEPTH];
  logic [INST_W-1:0] mem_inst_d [DEPTH];
  logic [PC_W-1:0]   mem_pc_q   [DEPTH];
  logic [PC_W-1:0]   mem_pc_d   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: an in-flight request reserves a slot, so a push can never overflow.
  always_comb begin
    credit_ok = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
    issue     = rst & fetch_en & ~redirect_valid & credit_ok;
    push      = inflight_q & ~redirect_valid;
    out_valid = (count_q != '0) & ~redirect_valid;
    pop       = out_valid & out_ready;
    imem_req  = issue;
    imem_addr = pc_q;
    out_inst  = mem_inst_q[rd_ptr_q];
    out_pc    = mem_pc_q[rd_ptr_q];
    occupancy = count_q;
  end

  // Next-state: redirect flushes queue and in-flight response; otherwise issue/push/pop.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_inst_d = mem_inst_q;
    mem_pc_d   = mem_pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        req_pc_d   = pc_q;
        inflight_d = 1'b1;
        pc_d       = pc_q + PC_W'(PC_STEP);
      end
      if (push) begin
        mem_inst_d[wr_ptr_q] = imem_data;
        mem_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset, storage included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= PC_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_inst_q <= mem_inst_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

endmodule
